// File: rtl/alu_acc_seq.sv
// alu_acc_seq: command sequencer and accumulator wrapped around a combinational 4-bit ALU.
module alu_acc_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic       in_load_i,
    input  logic [1:0] in_op_i,
    input  logic [3:0] in_operand_i,
    input  logic       in_cin_sel_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic       alu_c_o,
    output logic [1:0] alu_ctr_o,
    input  logic [3:0] alu_d_i,
    input  logic       alu_e_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [4:0] out_data_o,
    output logic [3:0] acc_o,
    output logic       carry_o,
    output logic       err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;
    state_t     state_q, state_d;
    logic [3:0] acc_q, acc_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0] alu_ctr_q, alu_ctr_d;
    logic [4:0] out_data_q, out_data_d;
    logic       carry_q, carry_d, err_q, err_d, alu_c_q, alu_c_d, out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_q     <= 1'b0;
            alu_ctr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_c_q     <= alu_c_d;
            alu_ctr_q   <= alu_ctr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // alu_ctr_q doubles as the latched opcode for the capture decision
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        err_d       = err_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_c_d     = alu_c_q;
        alu_ctr_d   = alu_ctr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                if (in_load_i) begin
                    acc_d       = in_operand_i;
                    carry_d     = 1'b0;
                    out_data_d  = {1'b0, in_operand_i};
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    alu_a_d   = acc_q;
                    alu_b_d   = in_operand_i;
                    alu_ctr_d = in_op_i;
                    alu_c_d   = (in_op_i == 2'b00 && in_cin_sel_i) ? carry_q : 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                acc_d       = alu_d_i;
                out_data_d  = {alu_e_i, alu_d_i};
                out_valid_d = 1'b1;
                carry_d     = (alu_ctr_q == 2'b00) ? alu_e_i : carry_q;
                err_d       = err_q | ((alu_ctr_q != 2'b00) & alu_e_i);
                state_d     = OUT;
            end
            default: if (out_ready_i) begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_c_o     = alu_c_q;
    assign alu_ctr_o   = alu_ctr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign acc_o       = acc_q;
    assign carry_o     = carry_q;
    assign err_o       = err_q;
endmodule
